// File: rtl/input_port_vc.sv
// rtl/input_port_vc.sv - mesh router input port: XY routing into five VC FIFOs with round-robin egress
module input_port_vc #(
  parameter int                DSIZE      = 32,
  parameter int                RRSIZE     = 8,
  parameter int                DEPTH_LOG2 = 5,
  parameter logic [2:0]        PORT       = 3'b000,
  parameter logic [RRSIZE-1:0] ROUTER_X   = '0,
  parameter logic [RRSIZE-1:0] ROUTER_Y   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DSIZE-1:0] data_in,
  input  logic             input_empty,
  output logic             input_read,
  input  logic [4:0]       recv_full,
  output logic [DSIZE-1:0] data_out,
  output logic             out_valid,
  output logic [2:0]       out_vc,
  output logic [4:0]       vc_full,
  output logic [4:0]       vc_empty,
  output logic             dropped
);
  localparam int NVC   = 5;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STALL} state_e;

  state_e                  state_q, state_d;
  logic [DSIZE-1:0]        hold_q, hold_d;
  logic [2:0]              hold_vc_q, hold_vc_d;
  logic                    drop_q, drop_d;
  logic [2:0]              last_grant_q;
  logic                    out_valid_q;
  logic [2:0]              out_vc_q;
  logic [DSIZE-1:0]        data_out_q;

  logic [DSIZE-1:0]        mem_q [NVC][DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_q [NVC];
  logic [DEPTH_LOG2-1:0]   rd_ptr_q [NVC];
  logic [DEPTH_LOG2:0]     count_q [NVC];

  logic                    wr_en;
  logic [2:0]              wr_vc;
  logic [DSIZE-1:0]        wr_data;
  logic [4:0]              push, pop, eligible;
  logic                    grant_any;
  logic [2:0]              grant_vc;
  logic [2:0]              in_route;
  logic                    in_uturn;

  function automatic logic [2:0] xy_route(input logic [DSIZE-1:0] flit);
    logic [RRSIZE-1:0] dx, dy;
    dx = flit[DSIZE-1 -: RRSIZE];
    dy = flit[DSIZE-RRSIZE-1 -: RRSIZE];
    if (dx > ROUTER_X)      return 3'd2;
    else if (dx < ROUTER_X) return 3'd3;
    else if (dy > ROUTER_Y) return 3'd0;
    else if (dy < ROUTER_Y) return 3'd1;
    else                    return 3'd4;
  endfunction

  assign in_route = xy_route(data_in);
  assign in_uturn = (in_route == PORT) && (PORT != 3'd4);

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_vc_d  = hold_vc_q;
    drop_d     = 1'b0;
    wr_en      = 1'b0;
    wr_vc      = in_route;
    wr_data    = data_in;
    input_read = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!input_empty) begin
          input_read = 1'b1;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (in_uturn) drop_d = 1'b1;
        else if (!vc_full[in_route]) wr_en = 1'b1;
        if (!in_uturn && vc_full[in_route]) begin
          hold_d    = data_in;
          hold_vc_d = in_route;
          state_d   = S_STALL;
        end else if (!input_empty) begin
          input_read = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STALL: begin
        wr_vc   = hold_vc_q;
        wr_data = hold_q;
        if (!vc_full[hold_vc_q]) begin
          wr_en   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Never pop the upstream FIFO while held in reset.
    if (!reset) input_read = 1'b0;
  end

  // Round-robin search starting one past the last granted VC.
  always_comb begin
    int cand;
    cand      = 0;
    grant_any = 1'b0;
    grant_vc  = last_grant_q;
    for (int k = 1; k <= NVC; k++) begin
      cand = (int'(last_grant_q) + k) % NVC;
      if (!grant_any && eligible[cand]) begin
        grant_any = 1'b1;
        grant_vc  = 3'(cand);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NVC; i++) begin
      vc_full[i]  = count_q[i][DEPTH_LOG2];
      vc_empty[i] = (count_q[i] == '0);
    end
  end

  assign eligible = ~vc_empty & ~recv_full;
  assign push     = wr_en ? (5'(1) << wr_vc) : '0;
  assign pop      = grant_any ? (5'(1) << grant_vc) : '0;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NVC; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NVC; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NVC; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PTR_ONE;
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PTR_ONE;
        if (push[i] && !pop[i])      count_q[i] <= count_q[i] + CNT_ONE;
        else if (pop[i] && !push[i]) count_q[i] <= count_q[i] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      hold_q       <= '0;
      hold_vc_q    <= '0;
      drop_q       <= 1'b0;
      last_grant_q <= 3'd4;
      out_valid_q  <= 1'b0;
      out_vc_q     <= '0;
      data_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_vc_q   <= hold_vc_d;
      drop_q      <= drop_d;
      out_valid_q <= grant_any;
      if (grant_any) begin
        last_grant_q <= grant_vc;
        out_vc_q     <= grant_vc;
        data_out_q   <= mem_q[grant_vc][rd_ptr_q[grant_vc]];
      end
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign out_vc    = out_vc_q;
  assign dropped   = drop_q;
endmodule

// File: tb/tb_input_port_vc.sv
// tb/tb_input_port_vc.sv - self-checking bench for input_port_vc (local port and east-port instances)
module tb_input_port_vc;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [31:0] data_in, data_out;
  logic        input_empty, input_read, out_valid, dropped;
  logic [4:0]  recv_full, vc_full, vc_empty;
  logic [2:0]  out_vc;

  logic [31:0] u_data_in, u_data_out;
  logic        u_input_empty, u_input_read, u_out_valid, u_dropped;
  logic [4:0]  u_recv_full, u_vc_full, u_vc_empty;
  logic [2:0]  u_out_vc;

  input_port_vc #(.DSIZE(32), .RRSIZE(8), .DEPTH_LOG2(5), .PORT(3'd4),
                  .ROUTER_X(8'd2), .ROUTER_Y(8'd2)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .input_empty(input_empty),
    .input_read(input_read), .recv_full(recv_full), .data_out(data_out),
    .out_valid(out_valid), .out_vc(out_vc), .vc_full(vc_full),
    .vc_empty(vc_empty), .dropped(dropped));

  input_port_vc #(.DSIZE(32), .RRSIZE(8), .DEPTH_LOG2(5), .PORT(3'd2),
                  .ROUTER_X(8'd2), .ROUTER_Y(8'd2)) dut_u (
    .clk(clk), .reset(reset), .data_in(u_data_in), .input_empty(u_input_empty),
    .input_read(u_input_read), .recv_full(u_recv_full), .data_out(u_data_out),
    .out_valid(u_out_valid), .out_vc(u_out_vc), .vc_full(u_vc_full),
    .vc_empty(u_vc_empty), .dropped(u_dropped));

  typedef struct { logic [2:0] vc; logic [31:0] data; logic [4:0] rf; } obs_t;
  typedef struct { int dx; int dy; int exp_vc; } route_vec_t;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, first_rd_cyc = -1, first_ov_cyc = -1;
  logic [31:0] up_q[$], u_up_q[$];
  obs_t        obs_q[$];
  logic [4:0]  rf_prev = '0;
  logic [31:0] exp_q [5][$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int ref_route(input int dx, input int dy);
    if (dx > 2) return 2;
    if (dx < 2) return 3;
    if (dy > 2) return 0;
    if (dy < 2) return 1;
    return 4;
  endfunction

  function automatic logic [31:0] mk_flit(input int dx, input int dy, input int tag);
    return {8'(dx), 8'(dy), 16'(tag)};
  endfunction

  // Upstream FIFO models: a pop seen in cycle t presents the next word after that edge.
  initial begin
    bit rd_seen;
    data_in = '0; input_empty = 1'b1;
    forever begin
      @(negedge clk); rd_seen = input_read;
      @(posedge clk); #1;
      if (rd_seen && up_q.size() > 0) data_in = up_q.pop_front();
      input_empty = (up_q.size() == 0);
    end
  end

  initial begin
    bit rd_seen;
    u_data_in = '0; u_input_empty = 1'b1;
    forever begin
      @(negedge clk); rd_seen = u_input_read;
      @(posedge clk); #1;
      if (rd_seen && u_up_q.size() > 0) u_data_in = u_up_q.pop_front();
      u_input_empty = (u_up_q.size() == 0);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (out_valid) obs_q.push_back('{out_vc, data_out, rf_prev});
      rf_prev = recv_full;
      if (input_read && first_rd_cyc < 0) first_rd_cyc = cyc;
      if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
    end
  end

  task automatic wait_obs(input int n, input int budget, input string name);
    int k = 0;
    while (obs_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    check({name, "_count"}, obs_q.size(), n);
  endtask

  task automatic wait_vc_full(input int v, input int budget, input string name);
    int k = 0;
    while (!vc_full[v] && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({name, "_vc_full_reached"}, vc_full[v], 1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    up_q.delete(); u_up_q.delete();
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    obs_q.delete();
  endtask

  task automatic route_run(input route_vec_t rt[5], input int tag0, input string name);
    obs_q.delete();
    first_rd_cyc = -1; first_ov_cyc = -1;
    @(posedge clk); #2;
    for (int i = 0; i < 5; i++) up_q.push_back(mk_flit(rt[i].dx, rt[i].dy, tag0 + i));
    wait_obs(5, 60, name);
    for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
      check({name, "_vc"}, obs_q[i].vc, rt[i].exp_vc);
      check({name, "_data"}, obs_q[i].data, mk_flit(rt[i].dx, rt[i].dy, tag0 + i));
    end
  endtask

  initial begin
    route_vec_t rt[5];
    int bad, cnt, v, pushed, k;
    logic [4:0] pat [6];
    rt[0] = '{3, 2, 2}; rt[1] = '{1, 2, 3}; rt[2] = '{2, 3, 0};
    rt[3] = '{2, 1, 1}; rt[4] = '{2, 2, 4};
    recv_full = '0; u_recv_full = '0;

    // Reset values
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_input_read", input_read, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_out_vc", out_vc, 0);
    check("rst_dropped", dropped, 0);
    check("rst_vc_empty", vc_empty, 5'b11111);
    check("rst_vc_full", vc_full, 5'b00000);
    reset = 1'b1;
    obs_q.delete();
    repeat (10) @(negedge clk);
    check("idle_no_valid", obs_q.size(), 0);

    // XY routing and first-flit latency
    route_run(rt, 16, "route");
    check("route_latency", first_ov_cyc - first_rd_cyc, 3);

    // Backpressure on E: 32 fill the VC, the 33rd stalls, the 34th stays upstream
    recv_full = 5'b00100;
    obs_q.delete();
    for (int i = 0; i < 34; i++) up_q.push_back(mk_flit(3, 2, 100 + i));
    wait_vc_full(2, 120, "bp");
    bad = 0;
    repeat (10) begin @(negedge clk); if (input_read) bad++; end
    check("bp_read_held_low", bad, 0);
    check("bp_vc_full", vc_full, 5'b00100);
    check("bp_upstream_left", up_q.size(), 1);
    check("bp_no_egress", obs_q.size(), 0);
    @(posedge clk); #2 recv_full = '0;
    wait_obs(34, 200, "bp");
    bad = 0;
    for (int i = 0; i < obs_q.size(); i++)
      if (obs_q[i].vc !== 3'd2 || obs_q[i].data !== mk_flit(3, 2, 100 + i)) bad++;
    check("bp_order", bad, 0);

    // Round-robin: VC0 has first priority after reset
    do_reset();
    recv_full = 5'b11111;
    for (int i = 0; i < 2; i++) up_q.push_back(mk_flit(2, 3, 200 + i));
    for (int i = 0; i < 2; i++) up_q.push_back(mk_flit(3, 2, 202 + i));
    for (int i = 0; i < 2; i++) up_q.push_back(mk_flit(2, 2, 204 + i));
    repeat (15) @(negedge clk);
    check("rr_preload_empty", vc_empty, 5'b01010);
    @(posedge clk); #2 recv_full = '0;
    wait_obs(6, 30, "rr");
    pat = '{3'd0, 3'd2, 3'd4, 3'd0, 3'd2, 3'd4};
    for (int i = 0; i < 6 && i < obs_q.size(); i++) check("rr_order", obs_q[i].vc, pat[i]);

    recv_full = 5'b11111;
    obs_q.delete();
    for (int i = 0; i < 2; i++) up_q.push_back(mk_flit(2, 3, 210 + i));
    for (int i = 0; i < 2; i++) up_q.push_back(mk_flit(3, 2, 212 + i));
    for (int i = 0; i < 2; i++) up_q.push_back(mk_flit(2, 2, 214 + i));
    repeat (15) @(negedge clk);
    @(posedge clk); #2 recv_full = 5'b00100;
    k = 0;
    while (obs_q.size() < 4 && k < 30) begin @(negedge clk); k++; end
    repeat (4) @(negedge clk);
    check("rr_mask_count", obs_q.size(), 4);
    @(posedge clk); #2 recv_full = '0;
    wait_obs(6, 30, "rr_mask");
    pat = '{3'd0, 3'd4, 3'd0, 3'd4, 3'd2, 3'd2};
    for (int i = 0; i < 6 && i < obs_q.size(); i++) check("rr_mask_order", obs_q[i].vc, pat[i]);

    // Reset while VC1 holds 5 flits and a flit is stalled on full VC2
    recv_full = 5'b00110;
    for (int i = 0; i < 5; i++) up_q.push_back(mk_flit(2, 1, 300 + i));
    for (int i = 0; i < 33; i++) up_q.push_back(mk_flit(3, 2, 310 + i));
    wait_vc_full(2, 150, "mid");
    repeat (3) @(negedge clk);
    check("mid_pre_vc_empty", vc_empty, 5'b11001);
    @(posedge clk); #3 reset = 1'b0;
    #1;
    check("mid_rst_ctrl", {input_read, out_valid, out_vc, dropped, vc_full, vc_empty},
          {1'b0, 1'b0, 3'd0, 1'b0, 5'b00000, 5'b11111});
    check("mid_rst_data_out", data_out, 0);
    up_q.delete();
    recv_full = '0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    obs_q.delete();
    repeat (10) @(negedge clk);
    check("mid_no_stale", obs_q.size(), 0);
    route_run(rt, 400, "mid_route");

    // U-turn on the east port
    @(posedge clk); #2 u_up_q.push_back(mk_flit(3, 2, 500));
    cnt = 0; bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (u_dropped) cnt++;
      if (u_vc_empty !== 5'b11111 || u_out_valid) bad++;
    end
    check("uturn_drop_pulses", cnt, 1);
    check("uturn_no_write", bad, 0);
    @(posedge clk); #2 u_up_q.push_back(mk_flit(1, 2, 501));
    k = 0;
    while (!u_out_valid && k < 20) begin
      @(negedge clk);
      if (u_dropped) cnt++;
      k++;
    end
    check("uturn_w_vc", {u_out_valid, u_out_vc}, {1'b1, 3'd3});
    check("uturn_w_data", u_data_out, mk_flit(1, 2, 501));
    check("uturn_drop_total", cnt, 1);

    // Random traffic against per-VC reference queues
    do_reset();
    pushed = 0;
    k = 0;
    while (pushed < 300 && k < 5000) begin
      @(posedge clk); #2;
      recv_full = 5'($urandom & $urandom);
      if ($urandom_range(0, 3) != 0) begin
        int dx, dy;
        dx = $urandom_range(0, 4);
        dy = $urandom_range(0, 4);
        up_q.push_back(mk_flit(dx, dy, 1000 + pushed));
        exp_q[ref_route(dx, dy)].push_back(mk_flit(dx, dy, 1000 + pushed));
        pushed++;
      end
      k++;
    end
    @(posedge clk); #2 recv_full = '0;
    wait_obs(300, 3000, "rand");
    for (int i = 0; i < obs_q.size(); i++) begin
      v = int'(obs_q[i].vc);
      check("rand_route", v, ref_route(int'(obs_q[i].data[31:24]), int'(obs_q[i].data[23:16])));
      check("rand_recv_full_respected", obs_q[i].rf[v], 0);
      if (v < 5 && exp_q[v].size() > 0) check("rand_vc_order", obs_q[i].data, exp_q[v].pop_front());
      else check("rand_unexpected_flit", obs_q[i].data, 32'hFFFF_FFFF);
    end
    cnt = 0;
    for (int i = 0; i < 5; i++) cnt += exp_q[i].size();
    check("rand_none_lost", cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
